// File: rtl/dmem_ctrl_pkg.sv
// Shared constants for the data-memory arbiter: access sizes, port ids, FSM states.
// Optional feature macro used by the design: MISALIGN_TRAP_EN.
package dmem_ctrl_pkg;

    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b10;
    localparam logic [1:0] SIZE_RSV = 2'b11;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_REQ = 3'd1,
        ST_RD_CAP = 3'd2,
        ST_WR     = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    // Reserved size behaves as a full word unless trapping is enabled.
    function automatic logic is_word(input logic [1:0] size);
        return (size == SIZE_W) || (size == SIZE_RSV);
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_H:   return lo[0];
            SIZE_W:   return lo != 2'b00;
            SIZE_RSV: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_ctrl_if.sv
// Requester and memory-side bundle for dmem_arbiter_ctrl.
// MISALIGN_TRAP_EN adds the per-port err pulses.
interface dmem_arbiter_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [31:0]       r0_wdata;
    logic [1:0]        r0_size;
    logic              r0_unsigned;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [31:0]       r0_rdata;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [31:0]       r1_wdata;
    logic [1:0]        r1_size;
    logic              r1_unsigned;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [31:0]       r1_rdata;

`ifdef MISALIGN_TRAP_EN
    logic              r0_err;
    logic              r1_err;
`endif

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic              mem_wen;
    logic              mem_ren;
    logic [31:0]       mem_rd;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata, r0_size, r0_unsigned,
        output r0_gnt, r0_rvalid, r0_rdata,
        input  r1_req, r1_we, r1_addr, r1_wdata, r1_size, r1_unsigned,
        output r1_gnt, r1_rvalid, r1_rdata,
`ifdef MISALIGN_TRAP_EN
        output r0_err, r1_err,
`endif
        output mem_addr, mem_wd, mem_wen, mem_ren,
        input  mem_rd
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata, r0_size, r0_unsigned,
        input  r0_gnt, r0_rvalid, r0_rdata,
        output r1_req, r1_we, r1_addr, r1_wdata, r1_size, r1_unsigned,
        input  r1_gnt, r1_rvalid, r1_rdata,
`ifdef MISALIGN_TRAP_EN
        input  r0_err, r1_err,
`endif
        input  mem_addr, mem_wd, mem_wen, mem_ren,
        output mem_rd
    );

endinterface

// File: rtl/dmem_lane_unit.sv
// Little-endian sub-word lane logic: load extraction/extension and store merge.
// Reserved size is handled as a word here; trapping (MISALIGN_TRAP_EN) is decided upstream.
module dmem_lane_unit
    import dmem_ctrl_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        unsgn,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = mem_word[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        load_data = mem_word;
        case (size)
            SIZE_B:  load_data = {{24{~unsgn & byte_sel[7]}}, byte_sel};
            SIZE_H:  load_data = {{16{~unsgn & half_sel[15]}}, half_sel};
            default: load_data = mem_word;
        endcase
    end

    // Only the addressed lane is replaced; the rest comes from the read word.
    always_comb begin
        store_word = mem_word;
        case (size)
            SIZE_B: store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            SIZE_H: begin
                if (addr_lo[1]) store_word[31:16] = wdata[15:0];
                else            store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter_ctrl.sv
// Two-port round-robin arbiter in front of a word-only single-port data memory,
// adding byte/half loads and read-modify-write stores. Optional: MISALIGN_TRAP_EN.
module dmem_arbiter_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int   ADDR_W     = 32,
    parameter logic RESET_PRIO = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_arbiter_ctrl_if.slave bus
);

    state_t            state;
    logic              last_grant;
    logic              id_q;
    logic              we_q;
    logic [1:0]        addr_lo_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              uns_q;

    logic              wen_q;
    logic              ren_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wd_q;
    logic [1:0]        rvalid_q;
    logic [31:0]       rdata0_q;
    logic [31:0]       rdata1_q;

    logic [1:0]        req;
    logic              win;
    logic              take;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [1:0]        sel_size;
    logic              sel_uns;
    logic [31:0]       ld_ext;
    logic [31:0]       st_merged;

    assign req = {bus.r1_req, bus.r0_req};

    // On a tie the port that did not win last time goes first.
    always_comb begin
        if (&req) win = ~last_grant;
        else      win = req[1];
    end

    assign take       = rst_n && (state == ST_IDLE) && (|req);
    assign bus.r0_gnt = take && (win == P0);
    assign bus.r1_gnt = take && (win == P1);

    assign sel_we    = win ? bus.r1_we       : bus.r0_we;
    assign sel_addr  = win ? bus.r1_addr     : bus.r0_addr;
    assign sel_wdata = win ? bus.r1_wdata    : bus.r0_wdata;
    assign sel_size  = win ? bus.r1_size     : bus.r0_size;
    assign sel_uns   = win ? bus.r1_unsigned : bus.r0_unsigned;

    dmem_lane_unit u_lane (
        .size       (size_q),
        .addr_lo    (addr_lo_q),
        .unsgn      (uns_q),
        .mem_word   (bus.mem_rd),
        .wdata      (wdata_q),
        .load_data  (ld_ext),
        .store_word (st_merged)
    );

`ifdef MISALIGN_TRAP_EN
    logic [1:0] err_q;
    assign bus.r0_err = err_q[0];
    assign bus.r1_err = err_q[1];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= ~RESET_PRIO;
            id_q       <= P0;
            we_q       <= 1'b0;
            addr_lo_q  <= 2'b00;
            wdata_q    <= '0;
            size_q     <= SIZE_B;
            uns_q      <= 1'b0;
            wen_q      <= 1'b0;
            ren_q      <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            rvalid_q   <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
`ifdef MISALIGN_TRAP_EN
            err_q      <= '0;
`endif
        end else begin
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            rvalid_q <= '0;
`ifdef MISALIGN_TRAP_EN
            err_q    <= '0;
`endif
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        last_grant <= win;
                        id_q       <= win;
                        we_q       <= sel_we;
                        addr_lo_q  <= sel_addr[1:0];
                        wdata_q    <= sel_wdata;
                        size_q     <= sel_size;
                        uns_q      <= sel_uns;
`ifdef MISALIGN_TRAP_EN
                        if (misaligned(sel_size, sel_addr[1:0])) begin
                            state         <= ST_RESP;
                            rvalid_q[win] <= 1'b1;
                            err_q[win]    <= 1'b1;
                        end else
`endif
                        if (sel_we && is_word(sel_size)) begin
                            state      <= ST_WR;
                            wen_q      <= 1'b1;
                            mem_addr_q <= {sel_addr[ADDR_W-1:2], 2'b00};
                            mem_wd_q   <= sel_wdata;
                        end else begin
                            state      <= ST_RD_REQ;
                            ren_q      <= 1'b1;
                            mem_addr_q <= {sel_addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                ST_RD_REQ: state <= ST_RD_CAP;
                ST_RD_CAP: begin
                    if (we_q) begin
                        state    <= ST_WR;
                        wen_q    <= 1'b1;
                        mem_wd_q <= st_merged;
                    end else begin
                        state          <= ST_RESP;
                        rvalid_q[id_q] <= 1'b1;
                        if (id_q == P1) rdata1_q <= ld_ext;
                        else            rdata0_q <= ld_ext;
                    end
                end
                ST_WR: begin
                    state          <= ST_RESP;
                    rvalid_q[id_q] <= 1'b1;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A write still pending when reset arrives never reaches the memory.
    assign bus.mem_wen   = wen_q & rst_n;
    assign bus.mem_ren   = ren_q & rst_n;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wd    = mem_wd_q;
    assign bus.r0_rvalid = rvalid_q[0];
    assign bus.r1_rvalid = rvalid_q[1];
    assign bus.r0_rdata  = rdata0_q;
    assign bus.r1_rdata  = rdata1_q;

endmodule

// File: doc/dmem_arbiter_ctrl.md
Name: dmem_arbiter_ctrl

Overview:
- Shares the single-port DATA_MEMORY between two requesters: port 0 (core LSU) and port 1 (debug/loader).
- Round-robin arbitration with a req/gnt/rvalid handshake.
- Adds RISC-V sub-word access on top of the word-only memory: byte/half loads with sign/zero extension; byte/half stores by read-modify-write.
- Sits between the LSU/debug master and DATA_MEMORY (Rd, Wd, Addr, Wen, Ren, clk).

Parameters:
- ADDR_W, 32, address width of requester and memory ports.
- RESET_PRIO, 0, requester treated as "last granted is the other one" after reset (0: port 0 wins first tie).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- r0_req  in  1  port 0 request; hold with fields stable until r0_gnt
- r0_we  in  1  1=store, 0=load
- r0_addr  in  ADDR_W  byte address
- r0_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- r0_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- r0_unsigned  in  1  load zero-extend when 1
- r0_gnt  out  1  one-cycle accept pulse
- r0_rvalid  out  1  one-cycle completion pulse (loads and stores)
- r0_rdata  out  32  extended load data, valid with r0_rvalid
- r1_req, r1_we, r1_addr, r1_wdata, r1_size, r1_unsigned, r1_gnt, r1_rvalid, r1_rdata: same as port 0, for port 1
- mem_addr  out  ADDR_W  to DATA_MEMORY Addr; bits [1:0] always 00
- mem_wd  out  32  to DATA_MEMORY Wd
- mem_wen  out  1  to DATA_MEMORY Wen
- mem_ren  out  1  to DATA_MEMORY Ren
- mem_rd  in  32  from DATA_MEMORY Rd; valid the cycle after mem_ren is high

Behaviour:
- Reset values: all gnt/rvalid/mem_wen/mem_ren = 0; rdata, mem_wd, mem_addr = 0; state IDLE; last_grant = ~RESET_PRIO.
- Reset is sampled on the clock edge only. Reset mid-transaction aborts it: no rvalid is issued, and any pending RMW write is dropped (memory unchanged).
- FSM states: IDLE, RD_REQ, RD_CAP, WR, RESP.
- IDLE:
  - Any req present: choose the winner and assert its gnt combinationally in the same cycle.
  - Latch we/addr/wdata/size/unsigned and the winner id at that edge.
  - Next state: load → RD_REQ; word store → WR; byte/half store → RD_REQ.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: winner = port != last_grant.
  - last_grant updates on every grant.
  - No grant is issued outside IDLE; reqs are held off.
- RD_REQ: mem_ren=1, mem_addr={addr[ADDR_W-1:2],2'b00} → RD_CAP.
- RD_CAP:
  - Capture mem_rd.
  - Load: build the extended result into the rdata register → RESP.
  - Sub-word store: build the merged word → WR.
- WR:
  - mem_wen=1, mem_addr aligned, mem_wd = wdata for word stores or the merged word for sub-word stores.
  - Next state: RESP.
- RESP: rvalid=1 on the winner port only; rdata is held until the next load completes on that port → IDLE.
- Latency, gnt cycle to rvalid cycle: word store 2, load 3, sub-word store 4 cycles.
- Maximum throughput: one transaction per 3/4/5 cycles.
- Lanes are little-endian:
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (bits [15:0] or [31:16]).
  - Load extension uses bit 7 or bit 15 of the selected lane unless unsigned.
- Merge replaces only the addressed lane with wdata[7:0] or wdata[15:0]; the other bytes are preserved from mem_rd.
- size=11 is treated as word (without the macro).
- mem_ren and mem_wen are never high in the same cycle.
- A new req arriving in RESP is granted in the following IDLE cycle. IDLE lasts at least 1 cycle between transactions.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Adds outputs r0_err and r1_err, which pulse with rvalid.
  - Half access with addr[0]=1, word access with addr[1:0]!=00, or size=11 → no memory access; IDLE → RESP directly; err=1; rdata unchanged.
- Undefined:
  - No err ports.
  - Low address bits below the access size are ignored (half uses addr[1], word ignores addr[1:0]).

Decomposition:
- Package dmem_ctrl_pkg holds:
  - SIZE_B/SIZE_H/SIZE_W/SIZE_RSV localparams.
  - FSM state encodings (3-bit).
  - Port id constants P0/P1.
- Sub-module dmem_lane_unit (combinational):
  - Inputs: size, addr[1:0], unsigned, mem word, wdata.
  - Outputs: extended load data and merged store word.
- The FSM and arbiter stay in the top level.

Test Plan:
- Reset, then r0 word store addr 0x10 data 0xDEADBEEF, then load → mem_wen for 1 cycle at 0x10; load rvalid 3 cycles after gnt; rdata=0xDEADBEEF.
- Mem 0x20=0x11223344; r1 store byte 0xAA at addr 0x22 → RD_REQ, RD_CAP, WR with mem_wd=0x11AA3344; rvalid 4 cycles after gnt.
- Mem 0x30=0x80F07F01:
  - signed byte load at 0x33 → 0xFFFFFF80; unsigned → 0x00000080.
  - signed half load at 0x30 → 0x00007F01; signed half at 0x32 → 0xFFFF80F0.
- r0_req and r1_req held high continuously, 6 transactions → grants alternate P0,P1,P0,P1,P0,P1 (RESET_PRIO=0); never two gnts in one cycle.
- rst_n low during the WR state of a sub-word store at 0x40 (0x55555555) → mem_wen=0 after that edge, no rvalid, mem 0x40 still 0x55555555.
- With MISALIGN_TRAP_EN: r0 word load at 0x41 → no mem_ren/mem_wen; r0_rvalid and r0_err pulse 1 cycle after gnt.
